// File: rtl/regfile_write_ctrl.sv
// Write-port controller for the 8x4 board register file: debounces the WR/FILL
// pushbuttons and issues single-cycle writes (manual, auto-increment or fill).
//
// state   | meaning
// S_IDLE  | waiting for a debounced WR or FILL press, WrEn low
// S_WRITE | single manual write in flight (WrEn high for one cycle)
// S_FILL  | writing the captured data to addresses 0..NUM_REGS-1, BUSY high
module regfile_write_ctrl #(
  parameter int NUM_REGS        = 8,
  parameter int REG_SIZE        = 4,
  parameter int ADDR_SIZE       = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 BTN_WR,
  input  logic                 BTN_FILL,
  input  logic                 AUTO_INC,
  input  logic [REG_SIZE-1:0]  DIN_SW,
  input  logic [ADDR_SIZE-1:0] WA_SW,
  output logic                 WrEn,
  output logic [ADDR_SIZE-1:0] WA,
  output logic [REG_SIZE-1:0]  DIN,
  output logic                 BUSY,
  output logic [ADDR_SIZE-1:0] PTR
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(NUM_REGS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FILL} state_t;

  logic [1:0] btn_raw;
  logic [1:0] evt;
  logic       evt_wr;
  logic       evt_fill;

  assign btn_raw  = {BTN_FILL, BTN_WR};
  assign evt_wr   = evt[0];
  assign evt_fill = evt[1];

  // Per button: 2-flop synchronizer, disagreement counter, rising-edge detect.
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          deb_prev_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge CLK) begin
      if (CLR) begin
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        deb_q      <= 1'b0;
        deb_prev_q <= 1'b0;
        cnt_q      <= '0;
      end else begin
        sync1_q    <= btn_raw[b];
        sync2_q    <= sync1_q;
        deb_prev_q <= deb_q;
        if (sync2_q == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb_q <= ~deb_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end

    assign evt[b] = deb_q & ~deb_prev_q;
  end

  state_t                 state_q, state_d;
  logic                   wren_q, wren_d;
  logic                   busy_q, busy_d;
  logic                   inc_q, inc_d;
  logic [ADDR_SIZE-1:0]   wa_q, wa_d;
  logic [ADDR_SIZE-1:0]   ptr_q, ptr_d;
  logic [ADDR_SIZE-1:0]   idx_q, idx_d;
  logic [REG_SIZE-1:0]    din_q, din_d;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= S_IDLE;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      inc_q   <= 1'b0;
      wa_q    <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
      inc_q   <= inc_d;
      wa_q    <= wa_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      din_q   <= din_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wren_d  = 1'b0;
    busy_d  = 1'b0;
    inc_d   = inc_q;
    wa_d    = wa_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    din_d   = din_q;
    case (state_q)
      S_IDLE: begin
        // FILL takes priority; a simultaneous WR event is simply discarded.
        if (evt_fill) begin
          state_d = S_FILL;
          idx_d   = '0;
          wa_d    = '0;
          din_d   = DIN_SW;
          wren_d  = 1'b1;
          busy_d  = 1'b1;
        end else if (evt_wr) begin
          state_d = S_WRITE;
          inc_d   = AUTO_INC;
          wa_d    = AUTO_INC ? ptr_q : WA_SW;
          din_d   = DIN_SW;
          wren_d  = 1'b1;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
        if (inc_q) begin
          ptr_d = (ptr_q == LAST) ? '0 : ptr_q + ADDR_SIZE'(1);
        end
      end
      S_FILL: begin
        if (idx_q == LAST) begin
          state_d = S_IDLE;
        end else begin
          idx_d  = idx_q + ADDR_SIZE'(1);
          wa_d   = idx_q + ADDR_SIZE'(1);
          wren_d = 1'b1;
          busy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign WrEn = wren_q;
  assign WA   = wa_q;
  assign DIN  = din_q;
  assign BUSY = busy_q;
  assign PTR  = ptr_q;

endmodule
